// File: rtl/rs_station_pkg.sv
// Shared widths, entry/issue record types and the tag-match helper for rs_station.
package rs_station_pkg;

  localparam int INSTR_ID_W = 6;
  localparam int IMM_W      = 32;
  localparam int ADDR_W     = 32;
  localparam int ROB_IDX_W  = 5;
  localparam int WORD_W     = 32;

  // One reservation-station slot.
  typedef struct packed {
    logic                  busy;
    logic [INSTR_ID_W-1:0] instr_id;
    logic [IMM_W-1:0]      imm;
    logic [ADDR_W-1:0]     pc;
    logic [ROB_IDX_W-1:0]  rob_pos;
    logic                  q1_busy;
    logic [ROB_IDX_W-1:0]  q1;
    logic [WORD_W-1:0]     v1;
    logic                  q2_busy;
    logic [ROB_IDX_W-1:0]  q2;
    logic [WORD_W-1:0]     v2;
  } rs_entry_t;

  // Registered issue payload handed to EX.
  typedef struct packed {
    logic [INSTR_ID_W-1:0] instr_id;
    logic [IMM_W-1:0]      imm;
    logic [ADDR_W-1:0]     pc;
    logic [ROB_IDX_W-1:0]  rob_pos;
    logic [WORD_W-1:0]     rs1;
    logic [WORD_W-1:0]     rs2;
  } rs_issue_t;

  // True when a valid broadcast carries the tag an operand is waiting on.
  function automatic logic tag_hit(input logic en,
                                   input logic [ROB_IDX_W-1:0] want,
                                   input logic [ROB_IDX_W-1:0] bcast);
    return en && (want == bcast);
  endfunction

endpackage

// File: rtl/rs_station_pick.sv
// Lowest-index-set priority encoder: reports whether any request bit is set
// and the index of the lowest one.
module rs_pick #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req_in,
  output logic             found_out,
  output logic [IDX_W-1:0] idx_out
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found_out = 1'b0;
    idx_out   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_in[i]) begin
        found_out = 1'b1;
        idx_out   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rs_station.sv
// Reservation station for the ALU/branch path. Holds dispatched instructions
// until both operands are valid, snoops EX and LSB result broadcasts, and
// issues the lowest-index ready entry each cycle.
//
// Handshake: rs_to_ex_en_out is a one-cycle valid with no ready; EX accepts
// every issue unconditionally. dispatch_en_in is likewise a valid with no
// ready; the decoder must watch full_out and not dispatch while it is high.
module rs_station
  import rs_station_pkg::*;
#(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX_W = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_in,
  input  logic                  dispatch_en_in,
  input  logic [INSTR_ID_W-1:0] instr_id_in,
  input  logic [IMM_W-1:0]      imm_in,
  input  logic [ADDR_W-1:0]     pc_in,
  input  logic [ROB_IDX_W-1:0]  rob_pos_in,
  input  logic                  q1_busy_in,
  input  logic                  q2_busy_in,
  input  logic [ROB_IDX_W-1:0]  q1_in,
  input  logic [ROB_IDX_W-1:0]  q2_in,
  input  logic [WORD_W-1:0]     v1_in,
  input  logic [WORD_W-1:0]     v2_in,
  input  logic                  ex_to_rs_en_in,
  input  logic [WORD_W-1:0]     ex_res_in,
  input  logic [ROB_IDX_W-1:0]  ex_rob_pos_in,
  input  logic                  lsb_to_rs_en_in,
  input  logic [WORD_W-1:0]     lsb_res_in,
  input  logic [ROB_IDX_W-1:0]  lsb_rob_pos_in,
  output logic                  full_out,
  output logic                  rs_to_ex_en_out,
  output logic [INSTR_ID_W-1:0] instr_id_out,
  output logic [IMM_W-1:0]      imm_out,
  output logic [ADDR_W-1:0]     pc_out,
  output logic [ROB_IDX_W-1:0]  rob_pos_out,
  output logic [WORD_W-1:0]     rs1_out,
  output logic [WORD_W-1:0]     rs2_out
);

  rs_entry_t entry_q [RS_SIZE];
  rs_entry_t entry_d [RS_SIZE];
  rs_issue_t issue_q, issue_d;
  logic      en_q, en_d;

  logic [RS_SIZE-1:0]  free_vec, ready_vec;
  logic                free_found, ready_found;
  logic [RS_IDX_W-1:0] free_idx, ready_idx;
  rs_entry_t           new_entry;

  // Free and ready vectors come from registered state only, so a same-cycle
  // issue never makes room for a same-cycle dispatch.
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i]  = !entry_q[i].busy;
      ready_vec[i] = entry_q[i].busy && !entry_q[i].q1_busy && !entry_q[i].q2_busy;
    end
  end

  rs_pick #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_pick_free (
    .req_in   (free_vec),
    .found_out(free_found),
    .idx_out  (free_idx)
  );

  rs_pick #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_pick_ready (
    .req_in   (ready_vec),
    .found_out(ready_found),
    .idx_out  (ready_idx)
  );

  assign full_out = !free_found;

  // Build the incoming entry, bypassing any operand whose producer is
  // broadcasting this very cycle; EX takes priority over LSB.
  always_comb begin
    new_entry          = '0;
    new_entry.busy     = 1'b1;
    new_entry.instr_id = instr_id_in;
    new_entry.imm      = imm_in;
    new_entry.pc       = pc_in;
    new_entry.rob_pos  = rob_pos_in;
    new_entry.q1_busy  = q1_busy_in;
    new_entry.q1       = q1_in;
    new_entry.v1       = v1_in;
    new_entry.q2_busy  = q2_busy_in;
    new_entry.q2       = q2_in;
    new_entry.v2       = v2_in;
    if (q1_busy_in) begin
      if (tag_hit(ex_to_rs_en_in, q1_in, ex_rob_pos_in)) begin
        new_entry.q1_busy = 1'b0;
        new_entry.v1      = ex_res_in;
      end else if (tag_hit(lsb_to_rs_en_in, q1_in, lsb_rob_pos_in)) begin
        new_entry.q1_busy = 1'b0;
        new_entry.v1      = lsb_res_in;
      end
    end
    if (q2_busy_in) begin
      if (tag_hit(ex_to_rs_en_in, q2_in, ex_rob_pos_in)) begin
        new_entry.q2_busy = 1'b0;
        new_entry.v2      = ex_res_in;
      end else if (tag_hit(lsb_to_rs_en_in, q2_in, lsb_rob_pos_in)) begin
        new_entry.q2_busy = 1'b0;
        new_entry.v2      = lsb_res_in;
      end
    end
  end

  // Next-state: freeze on !rdy_in, flush on clear_in, otherwise wakeup,
  // issue the lowest ready entry and accept a dispatch into the lowest free slot.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) entry_d[i] = entry_q[i];
    issue_d = '0;
    en_d    = 1'b0;
    if (!rdy_in) begin
      issue_d = issue_q;
      en_d    = en_q;
    end else if (clear_in) begin
      for (int i = 0; i < RS_SIZE; i++) entry_d[i].busy = 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (entry_q[i].busy && entry_q[i].q1_busy) begin
          if (tag_hit(ex_to_rs_en_in, entry_q[i].q1, ex_rob_pos_in)) begin
            entry_d[i].q1_busy = 1'b0;
            entry_d[i].v1      = ex_res_in;
          end else if (tag_hit(lsb_to_rs_en_in, entry_q[i].q1, lsb_rob_pos_in)) begin
            entry_d[i].q1_busy = 1'b0;
            entry_d[i].v1      = lsb_res_in;
          end
        end
        if (entry_q[i].busy && entry_q[i].q2_busy) begin
          if (tag_hit(ex_to_rs_en_in, entry_q[i].q2, ex_rob_pos_in)) begin
            entry_d[i].q2_busy = 1'b0;
            entry_d[i].v2      = ex_res_in;
          end else if (tag_hit(lsb_to_rs_en_in, entry_q[i].q2, lsb_rob_pos_in)) begin
            entry_d[i].q2_busy = 1'b0;
            entry_d[i].v2      = lsb_res_in;
          end
        end
      end
      if (ready_found) begin
        en_d             = 1'b1;
        issue_d.instr_id = entry_q[ready_idx].instr_id;
        issue_d.imm      = entry_q[ready_idx].imm;
        issue_d.pc       = entry_q[ready_idx].pc;
        issue_d.rob_pos  = entry_q[ready_idx].rob_pos;
        issue_d.rs1      = entry_q[ready_idx].v1;
        issue_d.rs2      = entry_q[ready_idx].v2;
        entry_d[ready_idx].busy = 1'b0;
      end
      if (dispatch_en_in && free_found) begin
        entry_d[free_idx] = new_entry;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) entry_q[i] <= '0;
      issue_q <= '0;
      en_q    <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) entry_q[i] <= entry_d[i];
      issue_q <= issue_d;
      en_q    <= en_d;
    end
  end

  // A pending issue held across a stall is only presented once rdy_in returns.
  assign rs_to_ex_en_out = en_q && rdy_in;
  assign instr_id_out    = issue_q.instr_id;
  assign imm_out         = issue_q.imm;
  assign pc_out          = issue_q.pc;
  assign rob_pos_out     = issue_q.rob_pos;
  assign rs1_out         = issue_q.rs1;
  assign rs2_out         = issue_q.rs2;

endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station: scenario tasks drive stimulus and push
// expected issues to a queue; a monitor pops and compares every issue.
module tb_rs_station;
  import rs_station_pkg::*;

  localparam int EXP_W = INSTR_ID_W + IMM_W + ADDR_W + ROB_IDX_W + 2 * WORD_W;
  localparam logic [INSTR_ID_W-1:0] OP_ADDI = 6'd1;
  localparam logic [INSTR_ID_W-1:0] OP_ADD  = 6'd2;

  logic                  clk_in, rst_in, rdy_in, clear_in, dispatch_en_in;
  logic [INSTR_ID_W-1:0] instr_id_in;
  logic [IMM_W-1:0]      imm_in;
  logic [ADDR_W-1:0]     pc_in;
  logic [ROB_IDX_W-1:0]  rob_pos_in, q1_in, q2_in;
  logic                  q1_busy_in, q2_busy_in;
  logic [WORD_W-1:0]     v1_in, v2_in;
  logic                  ex_to_rs_en_in, lsb_to_rs_en_in;
  logic [WORD_W-1:0]     ex_res_in, lsb_res_in;
  logic [ROB_IDX_W-1:0]  ex_rob_pos_in, lsb_rob_pos_in;
  logic                  full_out, rs_to_ex_en_out;
  logic [INSTR_ID_W-1:0] instr_id_out;
  logic [IMM_W-1:0]      imm_out;
  logic [ADDR_W-1:0]     pc_out;
  logic [ROB_IDX_W-1:0]  rob_pos_out;
  logic [WORD_W-1:0]     rs1_out, rs2_out;

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp_v, got_v;

  rs_station #(.RS_SIZE(16), .RS_IDX_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .dispatch_en_in(dispatch_en_in), .instr_id_in(instr_id_in), .imm_in(imm_in),
    .pc_in(pc_in), .rob_pos_in(rob_pos_in), .q1_busy_in(q1_busy_in),
    .q2_busy_in(q2_busy_in), .q1_in(q1_in), .q2_in(q2_in), .v1_in(v1_in),
    .v2_in(v2_in), .ex_to_rs_en_in(ex_to_rs_en_in), .ex_res_in(ex_res_in),
    .ex_rob_pos_in(ex_rob_pos_in), .lsb_to_rs_en_in(lsb_to_rs_en_in),
    .lsb_res_in(lsb_res_in), .lsb_rob_pos_in(lsb_rob_pos_in), .full_out(full_out),
    .rs_to_ex_en_out(rs_to_ex_en_out), .instr_id_out(instr_id_out), .imm_out(imm_out),
    .pc_out(pc_out), .rob_pos_out(rob_pos_out), .rs1_out(rs1_out), .rs2_out(rs2_out)
  );

  // Clock and watchdog.
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Scoreboard monitor: every issue must match the oldest expected entry.
  always @(posedge clk_in) begin
    #2;
    if (rst_in && rs_to_ex_en_out) begin
      got_v = {instr_id_out, imm_out, pc_out, rob_pos_out, rs1_out, rs2_out};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected issue got=%h with no expected entry", got_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL sb_issue got=%h exp=%h", got_v, exp_v);
        end
      end
    end
  end

  function automatic logic [EXP_W-1:0] pack_exp(
      input logic [INSTR_ID_W-1:0] id, input logic [IMM_W-1:0] imm,
      input logic [ADDR_W-1:0] pc, input logic [ROB_IDX_W-1:0] rob,
      input logic [WORD_W-1:0] rs1, input logic [WORD_W-1:0] rs2);
    return {id, imm, pc, rob, rs1, rs2};
  endfunction

  // Driver tasks.
  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic idle();
    dispatch_en_in  = 1'b0;
    ex_to_rs_en_in  = 1'b0;
    lsb_to_rs_en_in = 1'b0;
    clear_in        = 1'b0;
  endtask

  task automatic drv_dispatch(
      input logic [INSTR_ID_W-1:0] id, input logic [IMM_W-1:0] imm,
      input logic [ADDR_W-1:0] pc, input logic [ROB_IDX_W-1:0] rob,
      input logic q1b, input logic [ROB_IDX_W-1:0] q1, input logic [WORD_W-1:0] v1,
      input logic q2b, input logic [ROB_IDX_W-1:0] q2, input logic [WORD_W-1:0] v2);
    dispatch_en_in = 1'b1;
    instr_id_in = id; imm_in = imm; pc_in = pc; rob_pos_in = rob;
    q1_busy_in = q1b; q1_in = q1; v1_in = v1;
    q2_busy_in = q2b; q2_in = q2; v2_in = v2;
  endtask

  task automatic drv_ex(input logic [ROB_IDX_W-1:0] tag, input logic [WORD_W-1:0] val);
    ex_to_rs_en_in = 1'b1; ex_rob_pos_in = tag; ex_res_in = val;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain pending=%0d exp=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; idle();
    instr_id_in = '0; imm_in = '0; pc_in = '0; rob_pos_in = '0;
    q1_busy_in = 1'b0; q2_busy_in = 1'b0; q1_in = '0; q2_in = '0; v1_in = '0; v2_in = '0;
    ex_res_in = '0; ex_rob_pos_in = '0; lsb_res_in = '0; lsb_rob_pos_in = '0;
    tick(); tick();
    got_v = {instr_id_out, imm_out, pc_out, rob_pos_out, rs1_out, rs2_out};
    checks++;
    if (got_v !== '0 || rs_to_ex_en_out !== 1'b0 || full_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs data=%h en=%b full=%b exp all 0", got_v, rs_to_ex_en_out, full_out);
    end
    rst_in = 1'b1;
    tick();
    checks++;
    if (rs_to_ex_en_out !== 1'b0) begin
      errors++; $display("FAIL reset_idle en=%b exp=0", rs_to_ex_en_out);
    end
  endtask

  task automatic test_addi();
    drv_dispatch(OP_ADDI, 32'd3, 32'h1000, 5'd2, 1'b0, 5'd0, 32'd5, 1'b0, 5'd0, 32'd0);
    exp_q.push_back(pack_exp(OP_ADDI, 32'd3, 32'h1000, 5'd2, 32'd5, 32'd0));
    tick(); idle();
    checks++;
    if (rs_to_ex_en_out !== 1'b0) begin errors++; $display("FAIL addi_early en=%b exp=0", rs_to_ex_en_out); end
    tick();
    checks++;
    if (rs_to_ex_en_out !== 1'b1 || rs1_out !== 32'd5 || imm_out !== 32'd3 || rob_pos_out !== 5'd2) begin
      errors++;
      $display("FAIL addi_issue en=%b rs1=%h imm=%h rob=%0d exp 1/5/3/2", rs_to_ex_en_out, rs1_out, imm_out, rob_pos_out);
    end
    tick();
    checks++;
    if (rs_to_ex_en_out !== 1'b0) begin errors++; $display("FAIL addi_pulse en=%b exp=0", rs_to_ex_en_out); end
  endtask

  task automatic test_wakeup_ex();
    drv_dispatch(OP_ADD, 32'd0, 32'h1004, 5'd3, 1'b1, 5'd7, 32'hDEAD, 1'b0, 5'd0, 32'd9);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rs_to_ex_en_out !== 1'b0) begin errors++; $display("FAIL wake_wait en=%b exp=0", rs_to_ex_en_out); end
    end
    drv_ex(5'd7, 32'h10);
    exp_q.push_back(pack_exp(OP_ADD, 32'd0, 32'h1004, 5'd3, 32'h10, 32'd9));
    tick(); idle();
    checks++;
    if (rs_to_ex_en_out !== 1'b0) begin errors++; $display("FAIL wake_early en=%b exp=0", rs_to_ex_en_out); end
    tick();
    checks++;
    if (rs_to_ex_en_out !== 1'b1 || rs1_out !== 32'h10) begin
      errors++; $display("FAIL wake_issue en=%b rs1=%h exp 1/10", rs_to_ex_en_out, rs1_out);
    end
    tick();
  endtask

  task automatic test_bypass_lsb();
    drv_dispatch(OP_ADD, 32'd0, 32'h1008, 5'd6, 1'b0, 5'd0, 32'd1, 1'b1, 5'd4, 32'hDEAD);
    lsb_to_rs_en_in = 1'b1; lsb_rob_pos_in = 5'd4; lsb_res_in = 32'hABCD;
    exp_q.push_back(pack_exp(OP_ADD, 32'd0, 32'h1008, 5'd6, 32'd1, 32'hABCD));
    tick(); idle();
    tick();
    checks++;
    if (rs_to_ex_en_out !== 1'b1 || rs2_out !== 32'hABCD) begin
      errors++; $display("FAIL bypass_issue en=%b rs2=%h exp 1/abcd", rs_to_ex_en_out, rs2_out);
    end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      drv_dispatch(OP_ADD, 32'(i), 32'h100 + 32'(4 * i), 5'(i), 1'b1, 5'(16 + i), 32'hDEAD,
                   1'b0, 5'd0, 32'(3 * i));
      tick();
    end
    idle();
    checks++;
    if (full_out !== 1'b1) begin errors++; $display("FAIL full_set full=%b exp=1", full_out); end
    drv_dispatch(OP_ADDI, 32'd1, 32'h300, 5'd31, 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd1);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rs_to_ex_en_out !== 1'b0 || full_out !== 1'b1) begin
        errors++; $display("FAIL full_drop en=%b full=%b exp 0/1", rs_to_ex_en_out, full_out);
      end
    end
    drv_ex(5'd21, 32'h55);
    exp_q.push_back(pack_exp(OP_ADD, 32'd5, 32'h114, 5'd5, 32'h55, 32'd15));
    tick(); idle();
    checks++;
    if (full_out !== 1'b1) begin errors++; $display("FAIL full_ready_still full=%b exp=1", full_out); end
    tick();
    checks++;
    if (rs_to_ex_en_out !== 1'b1 || full_out !== 1'b0) begin
      errors++; $display("FAIL full_free en=%b full=%b exp 1/0", rs_to_ex_en_out, full_out);
    end
    clear_in = 1'b1; tick(); idle();
    checks++;
    if (full_out !== 1'b0) begin errors++; $display("FAIL full_flush full=%b exp=0", full_out); end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 10; i++) begin
      drv_dispatch(OP_ADD, 32'(i), 32'h400 + 32'(4 * i), 5'(i), 1'b1,
                   (i == 3 || i == 9) ? 5'd20 : 5'(10 + i), 32'hDEAD, 1'b0, 5'd0, 32'(i));
      tick();
    end
    idle();
    drv_ex(5'd20, 32'h33);
    exp_q.push_back(pack_exp(OP_ADD, 32'd3, 32'h40C, 5'd3, 32'h33, 32'd3));
    exp_q.push_back(pack_exp(OP_ADD, 32'd9, 32'h424, 5'd9, 32'h33, 32'd9));
    tick(); idle();
    tick();
    checks++;
    if (rs_to_ex_en_out !== 1'b1 || rob_pos_out !== 5'd3) begin
      errors++; $display("FAIL prio_first en=%b rob=%0d exp 1/3", rs_to_ex_en_out, rob_pos_out);
    end
    tick();
    checks++;
    if (rs_to_ex_en_out !== 1'b1 || rob_pos_out !== 5'd9) begin
      errors++; $display("FAIL prio_second en=%b rob=%0d exp 1/9", rs_to_ex_en_out, rob_pos_out);
    end
    tick();
    checks++;
    if (rs_to_ex_en_out !== 1'b0) begin errors++; $display("FAIL prio_done en=%b exp=0", rs_to_ex_en_out); end
    clear_in = 1'b1; tick(); idle();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) begin
      drv_dispatch(OP_ADD, 32'd0, 32'h500, 5'(10 + i), 1'b1, 5'(1 + i), 32'hDEAD, 1'b0, 5'd0, 32'd0);
      tick();
    end
    idle();
    clear_in = 1'b1;
    drv_dispatch(OP_ADDI, 32'd1, 32'h600, 5'd20, 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd0);
    tick(); idle();
    checks++;
    if (full_out !== 1'b0) begin errors++; $display("FAIL clear_full full=%b exp=0", full_out); end
    for (int i = 0; i < 5; i++) begin
      drv_ex(5'(1 + i), 32'h77);
      tick(); idle();
    end
    tick(); tick();
    checks++;
    if (rs_to_ex_en_out !== 1'b0) begin errors++; $display("FAIL clear_noissue en=%b exp=0", rs_to_ex_en_out); end
  endtask

  task automatic test_back_to_back();
    logic [WORD_W-1:0] res;
    drv_dispatch(OP_ADDI, 32'd7, 32'h200, 5'd8, 1'b0, 5'd0, 32'h20, 1'b0, 5'd0, 32'd0);
    exp_q.push_back(pack_exp(OP_ADDI, 32'd7, 32'h200, 5'd8, 32'h20, 32'd0));
    tick();
    drv_dispatch(OP_ADD, 32'd0, 32'h204, 5'd9, 1'b1, 5'd8, 32'hDEAD, 1'b0, 5'd0, 32'd1);
    tick(); idle();
    checks++;
    if (rs_to_ex_en_out !== 1'b1 || rob_pos_out !== 5'd8) begin
      errors++; $display("FAIL b2b_prod en=%b rob=%0d exp 1/8", rs_to_ex_en_out, rob_pos_out);
    end
    res = 32'h20 + 32'd7;
    drv_ex(5'd8, res);
    exp_q.push_back(pack_exp(OP_ADD, 32'd0, 32'h204, 5'd9, res, 32'd1));
    tick(); idle();
    checks++;
    if (rs_to_ex_en_out !== 1'b0) begin errors++; $display("FAIL b2b_gap en=%b exp=0", rs_to_ex_en_out); end
    tick();
    checks++;
    if (rs_to_ex_en_out !== 1'b1 || rob_pos_out !== 5'd9 || rs1_out !== res) begin
      errors++; $display("FAIL b2b_cons en=%b rob=%0d rs1=%h exp 1/9/%h", rs_to_ex_en_out, rob_pos_out, rs1_out, res);
    end
    tick();
  endtask

  task automatic test_rdy_freeze();
    drv_dispatch(OP_ADDI, 32'd4, 32'h700, 5'd11, 1'b0, 5'd0, 32'd2, 1'b0, 5'd0, 32'd0);
    exp_q.push_back(pack_exp(OP_ADDI, 32'd4, 32'h700, 5'd11, 32'd2, 32'd0));
    tick(); idle();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rs_to_ex_en_out !== 1'b0) begin errors++; $display("FAIL freeze_hold en=%b exp=0", rs_to_ex_en_out); end
    end
    rdy_in = 1'b1;
    tick();
    checks++;
    if (rs_to_ex_en_out !== 1'b1 || rob_pos_out !== 5'd11) begin
      errors++; $display("FAIL freeze_resume en=%b rob=%0d exp 1/11", rs_to_ex_en_out, rob_pos_out);
    end
    tick();
  endtask

  task automatic test_async_reset();
    drv_dispatch(OP_ADDI, 32'd8, 32'h800, 5'd12, 1'b0, 5'd0, 32'd6, 1'b0, 5'd0, 32'd0);
    exp_q.push_back(pack_exp(OP_ADDI, 32'd8, 32'h800, 5'd12, 32'd6, 32'd0));
    tick(); idle();
    tick();
    checks++;
    if (rs_to_ex_en_out !== 1'b1) begin errors++; $display("FAIL areset_pre en=%b exp=1", rs_to_ex_en_out); end
    #1 rst_in = 1'b0;
    #1;
    got_v = {instr_id_out, imm_out, pc_out, rob_pos_out, rs1_out, rs2_out};
    checks++;
    if (rs_to_ex_en_out !== 1'b0 || got_v !== '0 || full_out !== 1'b0) begin
      errors++; $display("FAIL areset_now en=%b data=%h full=%b exp all 0", rs_to_ex_en_out, got_v, full_out);
    end
    tick();
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [IMM_W-1:0]  imm;
    logic [WORD_W-1:0] a, b;
    for (int k = 0; k < 8; k++) begin
      imm = $urandom; a = $urandom; b = $urandom;
      drv_dispatch(6'($urandom_range(1, 20)), imm, 32'h900 + 32'(4 * k), 5'(k), 1'b0, 5'd0, a,
                   1'b0, 5'd0, b);
      exp_q.push_back(pack_exp(instr_id_in, imm, 32'h900 + 32'(4 * k), 5'(k), a, b));
      tick();
    end
    idle();
    wait_drain("random", 20);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_wakeup_ex();
    test_bypass_lsb();
    test_full();
    test_priority();
    test_clear();
    test_back_to_back();
    test_rdy_freeze();
    test_async_reset();
    test_random();
    wait_drain("final", 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
